des_decrypt_iter: RTL and testbench

//  Iterative DES decryption core: the receive-side counterpart of the DES encryption top level.

---
 rtl/des_pkg.sv | 142 ++++++++++++++
 rtl/des_f_function.sv | 24 ++
 rtl/des_decrypt_iter.sv | 123 ++++++++++++
 tb/tb_des_decrypt_iter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES definitions: permutation tables, S-boxes, key shift schedules,
// FSM state encoding and small permutation helpers. Used by both the
// encryption and decryption cores.
package des_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } des_state_e;

  // All tables use DES numbering: entry value 1 is the MSB of the source word.
  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  localparam int SHIFT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // Right-rotation amounts that walk C/D back from C16/D16 to C1/D1.
  localparam int SHIFT_DEC [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each S-box is stored row-major: index = row*16 + column.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - IP_TAB[6'(i)])];
    return o;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - FP_TAB[6'(i)])];
    return o;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[5'(32 - E_TAB[6'(i)])];
    return o;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = x[5'(32 - P_TAB[5'(i)])];
    return o;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = x[6'(64 - PC1_TAB[6'(i)])];
    return o;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[6'(56 - PC2_TAB[6'(i)])];
    return o;
  endfunction

  // Row is the outer bit pair, column the inner four bits.
  function automatic logic [3:0] sbox_lookup(input int n, input logic [5:0] b);
    logic [5:0]  idx;
    logic [31:0] v;
    idx = {b[5], b[0], b[4:1]};
    v   = SBOX[3'(n)][idx];
    return v[3:0];
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] c, input int n);
    logic [27:0] o;
    if (n == 1)      o = {c[0], c[27:1]};
    else if (n == 2) o = {c[1:0], c[27:2]};
    else             o = c;
    return o;
  endfunction

  // 1 when any byte of the key fails odd parity.
  function automatic logic key_parity_err(input logic [63:0] k);
    logic [63:0] kk;
    logic        err;
    kk  = k;
    err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (~^kk[7:0]) err = 1'b1;
      kk = kk >> 8;
    end
    return err;
  endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R,K) = P(S(E(R) ^ K)); purely combinational.
module des_f_function
  import des_pkg::*;
(
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] f_o
);

  logic [47:0] xs;
  logic [31:0] s;

  // Expand, mix with the subkey, then feed each 6-bit group (S1 first) to its S-box.
  always_comb begin
    xs = e_expand(r_i) ^ k_i;
    s  = '0;
    for (int n = 0; n < 8; n++) begin
      s  = {s[27:0], sbox_lookup(n, xs[47:42])};
      xs = xs << 6;
    end
    f_o = p_perm(s);
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption: one Feistel round per clock, subkeys K16..K1
// derived on the fly by right-rotating C/D.
//
//   state   | meaning
//   S_IDLE  | ready=1, waiting for load
//   S_ROUND | one round per edge, rnd = 0..15
//   S_FINAL | apply FP to the swapped halves, pulse done next cycle
module des_decrypt_iter
  import des_pkg::*;
#(
  parameter int KEY_PARITY_CHECK = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] key_in,
  input  logic [63:0] data_in,
  output logic        ready,
  output logic        done,
  output logic [63:0] data_out,
  output logic        key_err
);

  des_state_e  state_q, state_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [31:0] blk_l_q, blk_l_d, blk_r_q, blk_r_d;
  logic [27:0] key_c_q, key_c_d, key_d_q, key_d_d;
  logic [63:0] dout_q, dout_d;
  logic        done_q, done_d;
  logic        kerr_q, kerr_d;

  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] f_out;
  logic [63:0] ip_blk;
  logic [55:0] cd_init;

  // Subkey for the current round; rnd 0 uses C16/D16 = C0/D0 unrotated.
  always_comb begin
    c_rot  = rotr28(key_c_q, SHIFT_DEC[rnd_q]);
    d_rot  = rotr28(key_d_q, SHIFT_DEC[rnd_q]);
    subkey = pc2_perm({c_rot, d_rot});
  end

  des_f_function u_f (
    .r_i (blk_r_q),
    .k_i (subkey),
    .f_o (f_out)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_l_d = blk_l_q;
    blk_r_d = blk_r_q;
    key_c_d = key_c_q;
    key_d_d = key_d_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    kerr_d  = kerr_q;
    ip_blk  = ip_perm(data_in);
    cd_init = pc1_perm(key_in);
    case (state_q)
      S_IDLE: begin
        if (load) begin
          blk_l_d = ip_blk[63:32];
          blk_r_d = ip_blk[31:0];
          key_c_d = cd_init[55:28];
          key_d_d = cd_init[27:0];
          rnd_d   = 4'd0;
          kerr_d  = (KEY_PARITY_CHECK != 0) && key_parity_err(key_in);
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        key_c_d = c_rot;
        key_d_d = d_rot;
        blk_l_d = blk_r_q;
        blk_r_d = blk_l_q ^ f_out;
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == 4'd15) state_d = S_FINAL;
      end
      S_FINAL: begin
        dout_d  = fp_perm({blk_r_q, blk_l_q});
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      blk_l_q <= '0;
      blk_r_q <= '0;
      key_c_q <= '0;
      key_d_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      kerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_l_q <= blk_l_d;
      blk_r_q <= blk_r_d;
      key_c_q <= key_c_d;
      key_d_q <= key_d_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      kerr_q  <= kerr_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign done     = done_q;
  assign data_out = dout_q;
  assign key_err  = kerr_q;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter: one instance without and one with key parity checking.
module tb_des_decrypt_iter;

  logic        clk = 1'b0;
  logic        reset, load;
  logic [63:0] key_in, data_in;
  logic        ready0, done0, kerr0, ready1, done1, kerr1;
  logic [63:0] dout0, dout1;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] K1B = 64'h133457799BBCDFF0;
  localparam logic [63:0] C1  = 64'h85E813540F0AB405;
  localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2  = 64'h0000000000000000;
  localparam logic [63:0] P2  = 64'h8787878787878787;

  always #5 clk = ~clk;

  des_decrypt_iter #(.KEY_PARITY_CHECK(0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .key_in(key_in), .data_in(data_in),
    .ready(ready0), .done(done0), .data_out(dout0), .key_err(kerr0));

  des_decrypt_iter #(.KEY_PARITY_CHECK(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .key_in(key_in), .data_in(data_in),
    .ready(ready1), .done(done1), .data_out(dout1), .key_err(kerr1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (!ready1 && n < 50) begin
      tick;
      n++;
    end
    chk("ready_wait", 64'(ready1), 64'd1);
  endtask

  task automatic run_block(input string tag, input logic [63:0] k, input logic [63:0] c,
                           input logic [63:0] p);
    int lat;
    wait_ready;
    key_in  = k;
    data_in = c;
    load    = 1'b1;
    tick;
    load    = 1'b0;
    key_in  = ~k;
    data_in = ~c;
    chk({tag, "_busy"}, 64'(ready1), 64'd0);
    lat = 0;
    while (!done1 && lat < 40) begin
      tick;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd17);
    chk({tag, "_data"}, dout1, p);
    chk({tag, "_rdy_at_done"}, 64'(ready1), 64'd1);
    tick;
    chk({tag, "_done_pulse"}, 64'(done1), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  lat, gap;
    logic flag;
    reset = 1'b0; load = 1'b0; key_in = '0; data_in = '0;
    repeat (3) tick;
    chk("rst_ready", 64'(ready1), 64'd1);
    chk("rst_done",  64'(done1),  64'd0);
    chk("rst_dout",  dout1,       64'd0);
    chk("rst_kerr",  64'(kerr1),  64'd0);
    reset = 1'b1;
    tick;

    // Vector 1 and 2
    run_block("t1", K1, C1, P1);
    chk("t1_dut0_data", dout0, P1);
    chk("t1_kerr", 64'(kerr1), 64'd0);
    run_block("t2", K2, C2, P2);
    chk("t2_dut0_data", dout0, P2);

    // Load pulse while busy is ignored
    wait_ready;
    key_in = K1; data_in = C1; load = 1'b1;
    tick;
    load = 1'b0;
    flag = 1'b0;
    lat  = 0;
    while (!done1 && lat < 40) begin
      if (lat == 5) begin
        load = 1'b1; key_in = K2; data_in = C2;
      end else begin
        load = 1'b0;
      end
      tick;
      lat++;
      if (!done1 && ready1) flag = 1'b1;
    end
    load = 1'b0;
    chk("t3_lat", 64'(lat), 64'd17);
    chk("t3_data", dout1, P1);
    chk("t3_ready_low", 64'(flag), 64'd0);
    flag = 1'b0;
    repeat (20) begin
      tick;
      if (done1 || !ready1) flag = 1'b1;
    end
    chk("t3_not_queued", 64'(flag), 64'd0);

    // Reset in the middle of a block
    wait_ready;
    key_in = K1; data_in = C1; load = 1'b1;
    tick;
    load = 1'b0;
    repeat (7) tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("t4_ready", 64'(ready1), 64'd1);
    chk("t4_done",  64'(done1),  64'd0);
    chk("t4_dout",  dout1,       64'd0);
    chk("t4_dout0", dout0,       64'd0);
    flag = 1'b0;
    repeat (20) begin
      tick;
      if (done1) flag = 1'b1;
    end
    chk("t4_no_done", 64'(flag), 64'd0);
    run_block("t4b", K2, C2, P2);

    // Back-to-back with load held high
    wait_ready;
    key_in = K1; data_in = C1; load = 1'b1;
    tick;
    key_in = K2; data_in = C2;
    lat = 0;
    while (!done1 && lat < 40) begin
      tick;
      lat++;
    end
    chk("t5_lat", 64'(lat), 64'd17);
    chk("t5_data1", dout1, P1);
    tick;
    gap = 1;
    while (!done1 && gap < 40) begin
      tick;
      gap++;
    end
    load = 1'b0;
    chk("t5_gap", 64'(gap), 64'd18);
    chk("t5_data2", dout1, P2);
    tick;

    // Key parity reporting
    run_block("t6a", K1, C1, P1);
    chk("t6a_kerr", 64'(kerr1), 64'd0);
    run_block("t6b", K1B, C1, P1);
    chk("t6b_kerr", 64'(kerr1), 64'd1);
    chk("t6b_kerr_off", 64'(kerr0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
